// File: rtl/axi_slave_wr_arbiter.sv
// Write-path arbiter for one NoC slave port: QoS-aware round-robin grant of AW,
// held through the whole W burst; emits only handshake steering and a mux select.
module axi_slave_wr_arbiter #(
    parameter int NUM_M      = 4,
    parameter int QOS_W      = 4,
    parameter int LEN_W      = 4,
    parameter int ENABLE_QOS = 1
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [NUM_M-1:0]           m_awvalid,
    output logic [NUM_M-1:0]           m_awready,
    input  logic [NUM_M*QOS_W-1:0]     m_awqos,
    input  logic [NUM_M*LEN_W-1:0]     m_awlen,
    input  logic [NUM_M-1:0]           m_wvalid,
    input  logic [NUM_M-1:0]           m_wlast,
    output logic [NUM_M-1:0]           m_wready,
    output logic                       s_awvalid,
    input  logic                       s_awready,
    output logic                       s_wvalid,
    input  logic                       s_wready,
    output logic                       s_wlast,
    output logic [$clog2(NUM_M)-1:0]   gnt_idx,
    output logic                       busy,
    output logic                       err_wlast
);

    localparam int IDX_W = $clog2(NUM_M);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AW,
        ST_W
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   rr_ptr;
    logic [LEN_W:0]     beat_cnt;
    logic [IDX_W-1:0]   winner;
    logic [QOS_W-1:0]   max_qos;
    logic [NUM_M-1:0]   cand;
    logic [LEN_W-1:0]   gnt_len;
    logic               aw_hs;
    logic               w_hs;
    logic               last_beat;
    logic               w_end;

    // Candidate set and rotating search starting at rr_ptr.
    always_comb begin
        logic [IDX_W:0] pos;
        logic           found;
        max_qos = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (m_awvalid[i] && m_awqos[i*QOS_W +: QOS_W] > max_qos)
                max_qos = m_awqos[i*QOS_W +: QOS_W];
        end
        for (int i = 0; i < NUM_M; i++) begin
            cand[i] = m_awvalid[i] &&
                      (ENABLE_QOS == 0 || m_awqos[i*QOS_W +: QOS_W] == max_qos);
        end
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_M; k++) begin
            pos = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(NUM_M))
                pos = pos - (IDX_W+1)'(NUM_M);
            if (!found && cand[pos[IDX_W-1:0]]) begin
                winner = pos[IDX_W-1:0];
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_len = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (gnt_idx == IDX_W'(i))
                gnt_len = m_awlen[i*LEN_W +: LEN_W];
        end
    end

    assign aw_hs     = (state_q == ST_AW) && m_awvalid[gnt_idx] && s_awready;
    assign w_hs      = (state_q == ST_W)  && m_wvalid[gnt_idx]  && s_wready;
    assign last_beat = (beat_cnt == (LEN_W+1)'(1));
    // A burst closes on whichever comes first: the counted last beat or the master's WLAST.
    assign w_end     = w_hs && (last_beat || m_wlast[gnt_idx]);
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        m_awready = '0;
        m_wready  = '0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_wlast   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|m_awvalid)
                    state_d = ST_AW;
            end
            ST_AW: begin
                s_awvalid          = m_awvalid[gnt_idx];
                m_awready[gnt_idx] = s_awready;
                if (aw_hs)
                    state_d = ST_W;
            end
            ST_W: begin
                s_wvalid          = m_wvalid[gnt_idx];
                m_wready[gnt_idx] = s_wready;
                s_wlast           = last_beat;
                if (w_end)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            rr_ptr    <= '0;
            gnt_idx   <= '0;
            beat_cnt  <= '0;
            err_wlast <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_wlast <= 1'b0;
            if (state_q == ST_IDLE && |m_awvalid)
                gnt_idx <= winner;
            if (aw_hs) begin
                beat_cnt <= {1'b0, gnt_len} + (LEN_W+1)'(1);
                rr_ptr   <= (gnt_idx == IDX_W'(NUM_M-1)) ? '0 : gnt_idx + 1'b1;
            end
            if (w_hs)
                beat_cnt <= beat_cnt - 1'b1;
            if (w_end)
                err_wlast <= (m_wlast[gnt_idx] != last_beat);
        end
    end

endmodule

// File: tb/tb_axi_slave_wr_arbiter.sv
// Scoreboarded bench for axi_slave_wr_arbiter: behavioural masters feed the DUT,
// expected grant order and WLAST-error outcome are queued per test and popped per burst.
module tb_axi_slave_wr_arbiter;

    localparam int NUM_M = 4;
    localparam int QOS_W = 4;
    localparam int LEN_W = 4;

    logic                   ACLK = 1'b0;
    logic                   ARESET = 1'b1;
    logic [NUM_M-1:0]       m_awvalid = '0;
    logic [NUM_M-1:0]       m_awready;
    logic [NUM_M*QOS_W-1:0] m_awqos = '0;
    logic [NUM_M*LEN_W-1:0] m_awlen = '0;
    logic [NUM_M-1:0]       m_wvalid = '0;
    logic [NUM_M-1:0]       m_wlast = '0;
    logic [NUM_M-1:0]       m_wready;
    logic                   s_awvalid;
    logic                   s_awready = 1'b0;
    logic                   s_wvalid;
    logic                   s_wready = 1'b0;
    logic                   s_wlast;
    logic [1:0]             gnt_idx;
    logic                   busy;
    logic                   err_wlast;

    logic [NUM_M-1:0]       rr_m_awready;
    logic [NUM_M-1:0]       rr_m_wready;
    logic                   rr_s_awvalid;
    logic                   rr_s_wvalid;
    logic                   rr_s_wlast;
    logic [1:0]             rr_gnt_idx;
    logic                   rr_busy;
    logic                   rr_err_wlast;

    always #5 ACLK = ~ACLK;

    axi_slave_wr_arbiter #(.NUM_M(NUM_M), .QOS_W(QOS_W), .LEN_W(LEN_W), .ENABLE_QOS(1)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awqos(m_awqos), .m_awlen(m_awlen),
        .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_wlast(s_wlast), .gnt_idx(gnt_idx), .busy(busy), .err_wlast(err_wlast)
    );

    axi_slave_wr_arbiter #(.NUM_M(NUM_M), .QOS_W(QOS_W), .LEN_W(LEN_W), .ENABLE_QOS(0)) dut_rr (
        .ACLK(ACLK), .ARESET(ARESET),
        .m_awvalid(m_awvalid), .m_awready(rr_m_awready), .m_awqos(m_awqos), .m_awlen(m_awlen),
        .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(rr_m_wready),
        .s_awvalid(rr_s_awvalid), .s_awready(s_awready), .s_wvalid(rr_s_wvalid), .s_wready(s_wready),
        .s_wlast(rr_s_wlast), .gnt_idx(rr_gnt_idx), .busy(rr_busy), .err_wlast(rr_err_wlast)
    );

    typedef struct {
        int idx;
        bit err;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    bit               aw_pend  [NUM_M];
    bit               w_act    [NUM_M];
    int               len_v    [NUM_M];
    int               wlast_at [NUM_M];
    int               done_v   [NUM_M];
    int               total_v  [NUM_M];
    int               rep_left [NUM_M];
    logic [QOS_W-1:0] qos_v    [NUM_M];

    bit         rst_req = 1'b1;
    int         aw_hold = 0;
    bit         w_toggle = 1'b0;
    int         cyc = 0;
    bit         err_pending = 1'b0;
    bit         err_exp = 1'b0;
    bit         idle_pending = 1'b0;
    bit         busy_prev = 1'b0;
    logic [1:0] gnt_prev = '0;

    // wl < 0 means WLAST on the counted last beat; a large wl means WLAST never asserted.
    task automatic arm(input int i, input int l, input logic [QOS_W-1:0] q, input int wl);
        len_v[i]    = l;
        qos_v[i]    = q;
        wlast_at[i] = (wl < 0) ? l + 1 : wl;
        total_v[i]  = (l + 1 < wlast_at[i]) ? l + 1 : wlast_at[i];
        done_v[i]   = 0;
        aw_pend[i]  = 1'b1;
        w_act[i]    = 1'b1;
    endtask

    task automatic push_exp(input int i, input bit e);
        exp_t x;
        x.idx = i;
        x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_M; i++) begin
            aw_pend[i]  = 1'b0;
            w_act[i]    = 1'b0;
            rep_left[i] = 0;
            done_v[i]   = 0;
        end
        exp_q.delete();
        err_pending  = 1'b0;
        idle_pending = 1'b0;
        aw_hold      = 0;
        w_toggle     = 1'b0;
    endtask

    function automatic bit any_pending();
        bit p = 1'b0;
        for (int i = 0; i < NUM_M; i++)
            p |= aw_pend[i] | w_act[i];
        return p;
    endfunction

    task automatic tick();
        logic [NUM_M-1:0] mask;
        exp_t             e;
        @(negedge ACLK);
        cyc++;
        ARESET    = rst_req;
        s_awready = (aw_hold == 0);
        if (aw_hold > 0)
            aw_hold--;
        s_wready  = w_toggle ? cyc[0] : 1'b1;
        for (int i = 0; i < NUM_M; i++) begin
            m_awvalid[i]                 = aw_pend[i];
            m_wvalid[i]                  = w_act[i];
            m_wlast[i]                   = w_act[i] && (done_v[i] + 1 == wlast_at[i]);
            m_awqos[i*QOS_W +: QOS_W]    = qos_v[i];
            m_awlen[i*LEN_W +: LEN_W]    = LEN_W'(len_v[i]);
        end
        #1;
        if (ARESET) begin
            busy_prev = 1'b0;
            return;
        end

        checks++;
        if (err_wlast !== (err_pending ? err_exp : 1'b0)) begin
            errors++;
            $display("FAIL err_wlast cyc %0d: got %b want %b", cyc, err_wlast, err_pending ? err_exp : 1'b0);
        end
        err_pending = 1'b0;
        if (idle_pending) begin
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL burst_end_idle cyc %0d: busy got %b want 0", cyc, busy);
            end
            idle_pending = 1'b0;
        end
        if (busy === 1'b0) begin
            checks++;
            if ({s_awvalid, s_wvalid, m_awready, m_wready} !== '0) begin
                errors++;
                $display("FAIL idle_outputs cyc %0d: got awv=%b wv=%b awr=%b wr=%b want all 0",
                         cyc, s_awvalid, s_wvalid, m_awready, m_wready);
            end
        end else begin
            mask = ~(NUM_M'(1) << gnt_idx);
            checks++;
            if (((m_awready | m_wready) & mask) !== '0) begin
                errors++;
                $display("FAIL ungranted_ready cyc %0d: gnt %0d awr=%b wr=%b", cyc, gnt_idx, m_awready, m_wready);
            end
        end
        if (busy_prev && busy) begin
            checks++;
            if (gnt_idx !== gnt_prev) begin
                errors++;
                $display("FAIL grant_stable cyc %0d: got %0d want %0d", cyc, gnt_idx, gnt_prev);
            end
        end
        busy_prev = busy;
        gnt_prev  = gnt_idx;

        for (int i = 0; i < NUM_M; i++) begin
            if (m_awvalid[i] && m_awready[i]) begin
                aw_pend[i] = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL grant_order cyc %0d: got unexpected grant %0d", cyc, i);
                end else if (i != exp_q[0].idx || gnt_idx !== 2'(exp_q[0].idx) ||
                             s_awvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL grant_order cyc %0d: got master %0d gnt_idx %0d awvalid %b want %0d",
                             cyc, i, gnt_idx, s_awvalid, exp_q[0].idx);
                end
            end
        end

        for (int i = 0; i < NUM_M; i++) begin
            if (m_wvalid[i] && m_wready[i]) begin
                checks++;
                if (aw_pend[i] || s_wvalid !== 1'b1 ||
                    s_wlast !== (done_v[i] + 1 == len_v[i] + 1)) begin
                    errors++;
                    $display("FAIL w_beat cyc %0d: master %0d beat %0d got wlast %b wvalid %b want wlast %b",
                             cyc, i, done_v[i] + 1, s_wlast, s_wvalid, done_v[i] + 1 == len_v[i] + 1);
                end
                done_v[i]++;
                if (done_v[i] == total_v[i]) begin
                    w_act[i] = 1'b0;
                    if (exp_q.size() != 0) begin
                        e            = exp_q.pop_front();
                        err_exp      = e.err;
                        err_pending  = 1'b1;
                        idle_pending = 1'b1;
                    end
                    if (rep_left[i] > 0) begin
                        rep_left[i]--;
                        done_v[i]  = 0;
                        aw_pend[i] = 1'b1;
                        w_act[i]   = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic apply_reset();
        clear_model();
        rst_req = 1'b1;
        tick();
        tick();
        rst_req = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int n = 0; n < budget; n++) begin
            tick();
            if (exp_q.size() == 0 && !any_pending() && !err_pending && !idle_pending)
                return;
        end
        checks++;
        errors++;
        $display("FAIL timeout: %0d bursts still expected after %0d cycles", exp_q.size(), budget);
        apply_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        tick();
        checks++;
        if ({gnt_idx, busy, err_wlast, s_wlast, s_awvalid, s_wvalid, m_awready, m_wready} !== '0) begin
            errors++;
            $display("FAIL reset_state: got gnt %0d busy %b err %b wlast %b awv %b wv %b awr %b wr %b want all 0",
                     gnt_idx, busy, err_wlast, s_wlast, s_awvalid, s_wvalid, m_awready, m_wready);
        end
    endtask

    task automatic test_single();
        arm(1, 3, 4'd0, -1);
        push_exp(1, 1'b0);
        tick();
        checks++;
        if (s_awvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_req_cycle: got awvalid %b busy %b want 0 0", s_awvalid, busy);
        end
        tick();
        checks++;
        if (s_awvalid !== 1'b1 || gnt_idx !== 2'd1) begin
            errors++;
            $display("FAIL single_grant_latency: got awvalid %b gnt %0d want 1 1", s_awvalid, gnt_idx);
        end
        wait_done(40);
        // rr_ptr now 2: with M0 and M2 both requesting, M2 must win.
        arm(0, 0, 4'd0, -1);
        arm(2, 1, 4'd0, -1);
        push_exp(2, 1'b0);
        push_exp(0, 1'b0);
        wait_done(40);
    endtask

    task automatic test_rr_fairness();
        apply_reset();
        arm(0, 0, 4'd5, -1);
        arm(1, 1, 4'd5, -1);
        arm(2, 2, 4'd5, -1);
        arm(3, 1, 4'd5, -1);
        rep_left[0] = 1;
        push_exp(0, 1'b0);
        push_exp(1, 1'b0);
        push_exp(2, 1'b0);
        push_exp(3, 1'b0);
        push_exp(0, 1'b0);
        wait_done(80);
    endtask

    task automatic test_qos();
        apply_reset();
        arm(0, 1, 4'd2, -1);
        arm(2, 1, 4'd9, -1);
        arm(3, 1, 4'd9, -1);
        push_exp(2, 1'b0);
        push_exp(3, 1'b0);
        push_exp(0, 1'b0);
        tick();
        tick();
        checks++;
        if ({rr_m_awready, rr_m_wready, rr_s_wvalid, rr_s_wlast, rr_err_wlast, rr_busy, rr_s_awvalid, rr_gnt_idx}
            !== {4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL pure_rr_grant: got gnt %0d awv %b awr %b busy %b want gnt 0 awv 1 awr 0001 busy 1",
                     rr_gnt_idx, rr_s_awvalid, rr_m_awready, rr_busy);
        end
        wait_done(60);
    endtask

    task automatic test_backpressure();
        apply_reset();
        arm(3, 5, 4'd7, -1);
        arm(1, 2, 4'd3, -1);
        push_exp(3, 1'b0);
        push_exp(1, 1'b0);
        aw_hold  = 5;
        w_toggle = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (gnt_idx !== 2'd3 || s_awvalid !== 1'b1 || m_awready !== 4'b0000) begin
            errors++;
            $display("FAIL aw_stall: got gnt %0d awvalid %b awready %b want 3 1 0000", gnt_idx, s_awvalid, m_awready);
        end
        wait_done(80);
        w_toggle = 1'b0;
    endtask

    task automatic test_wlast_err();
        arm(2, 3, 4'd1, 2);
        push_exp(2, 1'b1);
        wait_done(40);
        arm(0, 0, 4'd1, 99);
        push_exp(0, 1'b1);
        wait_done(40);
    endtask

    task automatic test_reset_mid_burst();
        int n;
        arm(2, 7, 4'd0, -1);
        push_exp(2, 1'b0);
        n = 0;
        while (done_v[2] < 1 && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (done_v[2] != 1) begin
            errors++;
            $display("FAIL reset_mid_setup: got %0d beats want 1", done_v[2]);
        end
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        clear_model();
        tick();
        checks++;
        if ({gnt_idx, busy, err_wlast, s_wlast, s_awvalid, s_wvalid, m_awready, m_wready} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got gnt %0d busy %b err %b wlast %b awv %b wv %b want all 0",
                     gnt_idx, busy, err_wlast, s_wlast, s_awvalid, s_wvalid);
        end
        // rr_ptr back at 0: M1 must beat M3.
        arm(1, 1, 4'd4, -1);
        arm(3, 0, 4'd4, -1);
        push_exp(1, 1'b0);
        push_exp(3, 1'b0);
        wait_done(40);
    endtask

    initial begin
        clear_model();
        for (int i = 0; i < NUM_M; i++) begin
            len_v[i]    = 0;
            wlast_at[i] = 1;
            total_v[i]  = 1;
            qos_v[i]    = '0;
        end
        test_reset();
        test_single();
        test_rr_fairness();
        test_qos();
        test_backpressure();
        test_wlast_err();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
